// File: rtl/ooo_pipe_pkg.sv
// Shared types and widths for the out-of-order pipeline stage latches.
package ooo_pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_HALF  = 2'b01,
    ST_FULL  = 2'b10
  } stage_state_t;

  localparam int STALL_CNT_W  = 16;
  localparam int OOO_BUNDLE_W = 151;

endpackage

// File: rtl/stage_payload_reg.sv
// One WIDTH-bit payload bank: loads on en, holds otherwise, clears on a low clr_b.
module stage_payload_reg
  import ooo_pipe_pkg::*;
#(
  parameter int WIDTH = OOO_BUNDLE_W
) (
  input  logic             clk,
  input  logic             clr_b,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (en) data_d = d;
  end

  always_ff @(posedge clk) begin
    if (!clr_b) data_q <= '0;
    else        data_q <= data_d;
  end

  assign q = data_q;

endmodule

// File: rtl/ooo_stage_latch_ctrl.sv
// Two-entry valid/ready stage latch (main + skid bank) with single-cycle flush.
// Optional consumer stall counter on stall_cnt when OOO_STALL_CNT_EN is defined.
module ooo_stage_latch_ctrl
  import ooo_pipe_pkg::*;
#(
  parameter int WIDTH = OOO_BUNDLE_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
`ifdef OOO_STALL_CNT_EN
  output logic [STALL_CNT_W-1:0] stall_cnt,
`endif
  output logic [WIDTH-1:0]       out_data
);

  stage_state_t state_q, state_d;
  logic push, pop;
  logic main_en, skid_en, main_from_skid;
  logic [WIDTH-1:0] main_q, skid_q, main_d;

  // Handshake outputs decode only registered state, so no in->out comb paths.
  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d        = state_q;
    main_en        = 1'b0;
    skid_en        = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (push) begin
          state_d = ST_HALF;
          main_en = 1'b1;
        end
      end
      ST_HALF: begin
        if (push && pop) begin
          main_en = 1'b1;
        end else if (push) begin
          state_d = ST_FULL;
          skid_en = 1'b1;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) begin
          state_d        = ST_HALF;
          main_en        = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush drops everything, including a push offered in the same cycle.
    if (flush) begin
      state_d = ST_EMPTY;
      main_en = 1'b0;
      skid_en = 1'b0;
    end
  end

  assign main_d = main_from_skid ? skid_q : in_data;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  stage_payload_reg #(.WIDTH(WIDTH)) u_main (
    .clk   (clk),
    .clr_b (reset),
    .en    (main_en),
    .d     (main_d),
    .q     (main_q)
  );

  stage_payload_reg #(.WIDTH(WIDTH)) u_skid (
    .clk   (clk),
    .clr_b (reset),
    .en    (skid_en),
    .d     (in_data),
    .q     (skid_q)
  );

  assign out_data = main_q;

`ifdef OOO_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating; flush deliberately leaves it alone.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != {STALL_CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/ooo_stage_latch_ctrl.md
# ooo_stage_latch_ctrl

Two-entry, flow-controlled pipeline stage latch for the out-of-order core. It sequences the enables of two WIDTH-bit payload register banks (main and skid) so a producer and a consumer can exchange micro-op bundles with a valid/ready handshake at full throughput. A single-cycle flush empties it on mispredict or exception. It sits between decode/rename, the reservation stations and issue, wherever the 151-bit bundle crosses a stage boundary.

## Interface
- WIDTH, 151, payload width in bits.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset (low = reset).
- flush  in  1  discard all held entries this edge.
- in_valid  in  1  producer offers in_data.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  WIDTH  producer payload.
- out_valid  out  1  out_data holds a valid entry.
- out_ready  in  1  consumer accepts this cycle.
- out_data  out  WIDTH  oldest held payload; always the main bank.
- stall_cnt  out  16  consumer back-pressure cycle count. Present only with OOO_STALL_CNT_EN.

## Operation
- push = in_valid & in_ready; pop = out_valid & out_ready.
- State register: ST_EMPTY, ST_HALF, ST_FULL.
- Decoded outputs, registered state only, no combinational in→out paths:
  - in_ready = (state != ST_FULL).
  - out_valid = (state != ST_EMPTY).
- EMPTY:
  - push → HALF, main ← in_data.
- HALF:
  - push & pop → HALF, main ← in_data.
  - push & !pop → FULL, skid ← in_data.
  - !push & pop → EMPTY.
  - neither → HALF, hold.
- FULL:
  - pop → HALF, main ← skid.
  - !pop → hold.
  - push is impossible because in_ready = 0.
- FIFO order is preserved; an entry is never duplicated or dropped except by flush.
- Bank enables are asserted only on the loads listed above. Unloaded banks hold their value.
- flush = 1 → state ← ST_EMPTY at the edge and overrides push and pop. A push in the flush cycle is dropped even though in_ready was 1. Payload banks are not cleared.
- Reset (reset = 0 at the edge):
  - state ← ST_EMPTY; both banks ← 0.
  - Resulting outputs: out_valid = 0, in_ready = 1, out_data = 0, stall_cnt = 0.
  - Reset beats flush. Handshake inputs are ignored while reset is low, and mid-transfer entries are lost.

## Timing
- Latency: push at edge N → out_valid = 1 and out_data valid after edge N (cycle N+1).
- Throughput: 1 entry/cycle sustained while out_ready = 1.
- in_ready falls the cycle after the second unpopped push. It rises the cycle after a pop from FULL.
- A consumer stall therefore needs no combinational out_ready → in_ready path; the skid entry absorbs the extra beat.
- Flush at edge N → out_valid = 0, in_ready = 1 in cycle N+1. A push in cycle N+1 is accepted normally.

## Configuration
- OOO_STALL_CNT_EN defined:
  - stall_cnt increments each cycle with out_valid & !out_ready & reset.
  - Saturates at 16'hFFFF.
  - Cleared only by reset, not by flush.
- Undefined: stall_cnt port and counter are absent; the rest of the behaviour is identical.

## Structure
- Package ooo_pipe_pkg:
  - stage_state_t enum (ST_EMPTY = 2'b00, ST_HALF = 2'b01, ST_FULL = 2'b10).
  - STALL_CNT_W = 16.
  - OOO_BUNDLE_W = 151, used as the WIDTH default.
- Sub-module stage_payload_reg #(WIDTH): WIDTH-bit bank with per-bank enable and synchronous active-low clear. Instantiated twice (main, skid).
- Control FSM, enables and counter live in ooo_stage_latch_ctrl.

## Test plan
- Reset: hold reset = 0 two cycles with in_valid = 1 → out_valid = 0, in_ready = 1, out_data = 0, stall_cnt = 0; nothing accepted.
- Streaming: out_ready = 1, push 0x1, 0x2, 0x3 on consecutive cycles → out_data 0x1, 0x2, 0x3 one cycle after each push; in_ready stays 1.
- Back-pressure: out_ready = 0, push 0xA then 0xB → FULL, in_ready = 0; offered 0xC is not accepted. Release out_ready → pops 0xA, 0xB, then 0xC after re-accept, with no loss or duplicate. With OOO_STALL_CNT_EN, stall_cnt equals the stalled cycle count.
- Flush: FULL (0xA, 0xB), assert flush with in_valid = 1, in_data = 0xD → next cycle out_valid = 0, in_ready = 1; 0xD never appears.
- Simultaneous push/pop in HALF with 0x5 held, pushing 0x6 → state stays HALF, out_data = 0x6 next cycle; skid is never loaded.
- Counter saturation (macro on): force a 70000-cycle stall → stall_cnt = 16'hFFFF; a flush leaves it at 16'hFFFF.
